// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// The master side is fetch plus decode (drives enq data and deq_ready_D);
// the slave side is the queue itself.
interface fetch_queue_if;
    logic        enq_valid_F;
    logic [63:0] enq_pc_F;
    logic [31:0] enq_instr_F;
    logic        enq_ready_F;
    logic        deq_valid_D;
    logic [63:0] deq_pc_D;
    logic [31:0] deq_instr_D;
    logic        deq_ready_D;

    modport master (
        output enq_valid_F, enq_pc_F, enq_instr_F, deq_ready_D,
        input  enq_ready_F, deq_valid_D, deq_pc_D, deq_instr_D
    );

    modport slave (
        input  enq_valid_F, enq_pc_F, enq_instr_F, deq_ready_D,
        output enq_ready_F, deq_valid_D, deq_pc_D, deq_instr_D
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the LEGv8 fetch and decode stages.
// Circular buffer of {pc, instr} entries with valid/ready handshakes on
// both sides. A taken-branch redirect (flush_F) discards everything
// buffered. Readiness and validity come only from registered state, so
// there is no combinational path from decode back to fetch.
module fetch_queue #(
    parameter  int DEPTH = 4,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_F,
    fetch_queue_if.slave    q,
    output logic [PTRW:0]   count_o
);

    localparam logic [PTRW:0] FULL_COUNT = (PTRW + 1)'(DEPTH);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTRW-1:0]   wr_ptr;
    logic [PTRW-1:0]   rd_ptr;

    logic enq_fire;
    logic deq_fire;

    assign enq_fire = q.enq_valid_F & q.enq_ready_F;
    assign deq_fire = q.deq_valid_D & q.deq_ready_D;

    // Pointer and occupancy update; reset beats flush, and flush beats any handshake.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (reset || flush_F) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
            unique case ({enq_fire, deq_fire})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

    // Entry storage: cleared on reset, written only by a fire that is not being flushed.
    always_ff @(posedge clk) begin
        // NOTE: clearing every entry on reset is deliberate here; it keeps stale wrong-path words from ever being observable.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enq_fire && !flush_F) begin
            mem[wr_ptr] <= '{pc: q.enq_pc_F, instr: q.enq_instr_F};
        end
    end

    // Handshake outputs from registered state; head data forced to zero when empty.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        q.enq_ready_F = 1'b0;
        q.deq_valid_D = 1'b0;
        q.deq_pc_D    = '0;
        q.deq_instr_D = '0;
        q.enq_ready_F = (count_o != FULL_COUNT);
        q.deq_valid_D = (count_o != '0);
        if (q.deq_valid_D) begin
            q.deq_pc_D    = mem[rd_ptr].pc;
            q.deq_instr_D = mem[rd_ptr].instr;
        end
    end

    // Occupancy can never exceed the buffer size.
    count_in_range: assert property (@(posedge clk) disable iff (reset) count_o <= FULL_COUNT);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/stall, drain order,
// streaming across pointer wrap, flush with simultaneous handshakes and
// reset mid-operation. Inputs change 1 time unit after the rising edge,
// and outputs are checked at that point, away from the edge.
module tb_fetch_queue;

    logic       clk;
    logic       reset;
    logic       flush_F;
    logic [2:0] count;

    int total;
    int passed;
    int failed;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush_F (flush_F),
        .q       (bus.slave),
        .count_o (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] pc);
        bus.enq_valid_F = 1'b1;
        bus.enq_pc_F    = pc;
        bus.enq_instr_F = 32'h9100_0000 | pc[31:0];
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        reset           = 1'b1;
        flush_F         = 1'b0;
        bus.enq_valid_F = 1'b0;
        bus.enq_pc_F    = '0;
        bus.enq_instr_F = '0;
        bus.deq_ready_D = 1'b0;

        // 1. reset for two cycles, then a single enqueue with decode stalled
        step();
        step();
        reset = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_enq_ready", 64'(bus.enq_ready_F), 64'd1);
        check("rst_deq_valid", 64'(bus.deq_valid_D), 64'd0);
        check("rst_deq_pc", bus.deq_pc_D, 64'd0);
        check("rst_deq_instr", 64'(bus.deq_instr_D), 64'd0);

        bus.enq_valid_F = 1'b1;
        bus.enq_pc_F    = 64'h0;
        bus.enq_instr_F = 32'h8B02_0020;
        step();
        bus.enq_valid_F = 1'b0;
        check("t1_deq_valid", 64'(bus.deq_valid_D), 64'd1);
        check("t1_deq_pc", bus.deq_pc_D, 64'h0);
        check("t1_deq_instr", 64'(bus.deq_instr_D), 64'h8B02_0020);
        check("t1_count", 64'(count), 64'd1);

        // clear with a flush before filling
        flush_F = 1'b1;
        step();
        flush_F = 1'b0;
        check("flush_clear_count", 64'(count), 64'd0);

        // 2. fill and stall
        for (int i = 0; i < 4; i++) begin
            offer(64'(4 * i));
            step();
        end
        check("t2_count_full", 64'(count), 64'd4);
        check("t2_enq_ready_full", 64'(bus.enq_ready_F), 64'd0);
        offer(64'h10);
        step();
        bus.enq_valid_F = 1'b0;
        check("t2_refused_count", 64'(count), 64'd4);
        check("t2_head_pc", bus.deq_pc_D, 64'h0);

        // 3. drain in order; 0x10 must not follow
        bus.deq_ready_D = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_pc_%0d", i), bus.deq_pc_D, 64'(4 * i));
            check($sformatf("t3_instr_%0d", i), 64'(bus.deq_instr_D), 64'(32'h9100_0000 | 32'(4 * i)));
            step();
        end
        bus.deq_ready_D = 1'b0;
        check("t3_empty_valid", 64'(bus.deq_valid_D), 64'd0);
        check("t3_empty_pc", bus.deq_pc_D, 64'd0);
        check("t3_empty_instr", 64'(bus.deq_instr_D), 64'd0);
        check("t3_empty_count", 64'(count), 64'd0);
        check("t3_empty_ready", 64'(bus.enq_ready_F), 64'd1);

        // 4. streaming: enq and deq every cycle across pointer wrap
        bus.deq_ready_D = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(64'(4 * i));
            step();
            check($sformatf("t4_count_%0d", i), 64'(count), 64'd1);
            check($sformatf("t4_pc_%0d", i), bus.deq_pc_D, 64'(4 * i));
        end
        bus.enq_valid_F = 1'b0;
        step();
        bus.deq_ready_D = 1'b0;
        check("t4_drained_valid", 64'(bus.deq_valid_D), 64'd0);

        // 5. flush while decode takes the head and fetch offers 0xC
        for (int i = 0; i < 3; i++) begin
            offer(64'(4 * i));
            step();
        end
        bus.enq_valid_F = 1'b0;
        check("t5_count3", 64'(count), 64'd3);
        flush_F         = 1'b1;
        bus.deq_ready_D = 1'b1;
        offer(64'hC);
        check("t5_accept_valid", 64'(bus.deq_valid_D), 64'd1);
        check("t5_accept_pc", bus.deq_pc_D, 64'h0);
        step();
        flush_F         = 1'b0;
        bus.deq_ready_D = 1'b0;
        bus.enq_valid_F = 1'b0;
        check("t5_count", 64'(count), 64'd0);
        check("t5_deq_valid", 64'(bus.deq_valid_D), 64'd0);
        check("t5_enq_ready", 64'(bus.enq_ready_F), 64'd1);
        step();
        check("t5_no_0xC", 64'(bus.deq_valid_D), 64'd0);

        // 6. reset mid-operation with enq and flush also asserted
        offer(64'h100);
        step();
        offer(64'h104);
        step();
        check("t6_count2", 64'(count), 64'd2);
        reset   = 1'b1;
        flush_F = 1'b1;
        offer(64'h200);
        step();
        reset   = 1'b0;
        flush_F = 1'b0;
        offer(64'h40);
        check("t6_count", 64'(count), 64'd0);
        check("t6_deq_valid", 64'(bus.deq_valid_D), 64'd0);
        check("t6_enq_ready", 64'(bus.enq_ready_F), 64'd1);
        check("t6_deq_pc", bus.deq_pc_D, 64'd0);
        check("t6_deq_instr", 64'(bus.deq_instr_D), 64'd0);
        step();
        bus.enq_valid_F = 1'b0;
        check("t6_after_valid", 64'(bus.deq_valid_D), 64'd1);
        check("t6_after_pc", bus.deq_pc_D, 64'h40);
        check("t6_after_count", 64'(count), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue between the fetch stage and the decode stage of the LEGv8 pipeline.
- Captures {PC, instruction} pairs delivered by the fetch stage and instruction memory each cycle. Buffers up to DEPTH entries and presents them in order to decode with a valid/ready handshake.
- Absorbs decode stalls without losing fetched instructions.
- Discards all buffered entries when fetch redirects on a taken branch (PCSrc_F).

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- PTRW, $clog2(DEPTH), read/write pointer width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush_F  input  1  branch redirect (driven by PCSrc_F); clears the queue.
- enq_valid_F  input  1  fetch presents a valid {pc, instr} pair.
- enq_pc_F  input  64  PC of the presented instruction (imem_addr_F).
- enq_instr_F  input  32  instruction word read from imem at enq_pc_F.
- enq_ready_F  output  1  queue can accept; fetch holds its PC when low.
- deq_valid_D  output  1  head entry valid for decode.
- deq_pc_D  output  64  PC of head entry.
- deq_instr_D  output  32  instruction of head entry.
- deq_ready_D  input  1  decode consumes head this cycle.
- count_o  output  PTRW+1  current occupancy, 0..DEPTH.

Behaviour:
- Handshakes:
  - enq fire = enq_valid_F & enq_ready_F.
  - deq fire = deq_valid_D & deq_ready_D.
  - Both evaluated in the same cycle; updates take effect at the next rising edge.
- Storage: circular buffer of DEPTH entries {pc[63:0], instr[31:0]}.
  - wr_ptr and rd_ptr increment modulo DEPTH (natural wrap, PTRW bits).
  - count register is held separately.
- enq_ready_F = (count_o != DEPTH), purely from registered state.
  - No combinational path from deq_ready_D.
  - When full, enqueue is refused even if a dequeue happens that cycle.
- deq_valid_D = (count_o != 0).
- deq_pc_D / deq_instr_D show the head entry when deq_valid_D = 1, and are driven 0 when empty.
- Latency: an entry enqueued at edge N is visible on the deq outputs after edge N. Minimum fetch-to-decode latency is 1 cycle; there is no empty-queue bypass.
- Count update (no flush):
  - enq only: +1.
  - deq only: −1.
  - both: unchanged, with the write at wr_ptr and the read advance at rd_ptr.
  - neither: hold.
- Simultaneous enq+deq when count = 1: the head advances to the new entry; count stays 1.
- Flush (flush_F = 1 at an edge):
  - wr_ptr, rd_ptr and count are set to 0.
  - An enqueue offered that cycle is dropped (it is a wrong-path instruction).
  - A dequeue handshake completing that cycle is still considered accepted by decode. The queue does not retain or replay it.
  - flush_F has priority over enq/deq.
  - enq_ready_F is 1 and deq_valid_D is 0 in the next cycle.
- Reset (reset = 1 at an edge):
  - Same state as flush; storage contents are also cleared to 0.
  - Outputs after the reset edge: enq_ready_F = 1, deq_valid_D = 0, deq_pc_D = 0, deq_instr_D = 0, count_o = 0.
  - Reset mid-operation discards all entries; reset has priority over flush.
- Inputs are don't-care when enq_valid_F = 0. Storage is written only on enq fire.
- Illegal and unreachable: count_o > DEPTH. An assertion flags it in simulation.

Test Plan:
1. Reset then single pass:
   - Stimulus: reset 2 cycles; enq pc=0x0, instr=0x8B020020 with deq_ready_D = 0.
   - Response: the next cycle shows deq_valid_D = 1, deq_pc_D = 0x0, deq_instr_D = 0x8B020020, count_o = 1.
2. Fill and stall:
   - Stimulus: deq_ready_D = 0; enq pcs 0x0, 0x4, 0x8, 0xC on consecutive cycles.
   - Response: count_o = 4 and enq_ready_F = 0. A fifth offer (pc 0x10) is not accepted and count stays 4.
3. Drain order:
   - Stimulus: from full, deq_ready_D = 1 for 4 cycles with no enq.
   - Response: deq_pc_D sequence 0x0, 0x4, 0x8, 0xC; then deq_valid_D = 0 and the outputs read 0.
4. Streaming with wrap-around:
   - Stimulus: enq and deq every cycle for 10 cycles, pcs 0x0..0x24 step 4.
   - Response: count_o stays 1 after the first cycle. Decode sees each PC exactly once, in order, 1 cycle after enqueue, across pointer wrap.
5. Flush with simultaneous handshakes:
   - Stimulus: 3 entries (0x0, 0x4, 0x8); one cycle with flush_F = 1, deq_ready_D = 1, enq pc = 0xC.
   - Response: decode accepts 0x0 that cycle. The next cycle has count_o = 0, deq_valid_D = 0 and enq_ready_F = 1; 0xC is never delivered.
6. Reset mid-operation:
   - Stimulus: queue holds 2 entries; assert reset with enq_valid_F = 1 and flush_F = 1.
   - Response: after the edge, all outputs are at reset values and count_o = 0. A following enq of pc 0x40 appears at the head 1 cycle later.
